pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage MIPS pipeline.
- Drives the enable and flush controls of PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- Resolves three hazards: load-use, multi-cycle data-memory access (req/ack), and taken-branch squash.
- Watchdogs memory stalls and counts stall cycles for performance monitoring.

Parameters:
MEM_TIMEOUT, 64, consecutive unacknowledged memory-stall cycles before the error lock; 0 disables the timeout.
CNT_W, 16, width of stall_count.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
id_rs  input  5  rs field of instruction in ID
id_rt  input  5  rt field of instruction in ID
ex_mem_read  input  1  instruction in EX is a load (MemRead)
ex_rt  input  5  destination register of the load in EX
mem_req  input  1  instruction in MEM needs data memory this cycle
mem_ack  input  1  data memory completes the access this cycle
branch_taken  input  1  branch/jump resolved taken in EX
pc_enable  output  1  PC update enable
if_id_enable  output  1  IF_ID load enable
if_id_flush  output  1  IF_ID loads a NOP instead of its input
id_ex_enable  output  1  ID_EX load enable
id_ex_flush  output  1  ID_EX loads a bubble (all controls 0)
ex_mem_enable  output  1  EX_MEM load enable
mem_wb_enable  output  1  MEM_WB load enable
mem_error  output  1  sticky memory-timeout flag
stall_count  output  CNT_W  saturating count of cycles with pc_enable=0

Behaviour:
States are RUN, MEM_WAIT and ERROR. The state register updates on posedge clk. Control outputs are combinational from state and inputs.

Reset:
- When reset==0 at posedge: state=RUN, wait_cnt=0, mem_error=0, stall_count=0.
- While reset==0, all enables are forced to 0 and both flushes to 0.
- Reset mid-stall or in ERROR returns to RUN on that edge.

Flush semantics: a flush acts only when the stage's enable is 1. A register with enable=0 holds its contents regardless of its flush input.

RUN decision, highest priority first:
1. Memory stall when mem_req=1 and mem_ack=0:
   - All five enables 0, flushes 0.
   - Next state MEM_WAIT, wait_cnt=1.
   - If MEM_TIMEOUT==1, next state is ERROR instead.
2. Branch when branch_taken=1:
   - All enables 1, if_id_flush=1, id_ex_flush=1.
   - Load-use is ignored because the ID instruction is squashed.
3. Load-use when ex_mem_read=1, ex_rt!=0, and ex_rt==id_rs or ex_rt==id_rt:
   - pc_enable=0, if_id_enable=0.
   - id_ex_enable=1 with id_ex_flush=1.
   - ex_mem_enable=1, mem_wb_enable=1.
   - Exactly one bubble; the condition clears next cycle as the load advances.
4. Otherwise: all enables 1, flushes 0.
- mem_req=1 with mem_ack=1 in the same cycle is a single-cycle access: no stall, continue to rule 2.

MEM_WAIT:
- mem_ack=0:
  - All enables 0, flushes 0; wait_cnt increments.
  - If MEM_TIMEOUT!=0 and wait_cnt==MEM_TIMEOUT, next state ERROR and mem_error is set.
  - branch_taken is ignored; the branch is frozen in EX and re-presents after release.
- mem_ack=1:
  - Outputs follow RUN rules 2–4, evaluated on current inputs.
  - Next state RUN, wait_cnt=0.

ERROR:
- All enables 0, flushes 0, mem_error=1.
- Only reset exits.

wait_cnt width is clog2(MEM_TIMEOUT+1), minimum 1.

stall_count: increments at posedge whenever pc_enable=0 outside reset. Holds at all-ones; no wrap.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 for 1 cycle -> pc_enable=0, if_id_enable=0, id_ex_flush=1, ex_mem_enable=1, mem_wb_enable=1; stall_count 0→1. Repeat with ex_rt=0 -> no stall.
- Branch: branch_taken=1 with the same load-use condition -> all enables 1, if_id_flush=1, id_ex_flush=1, stall_count unchanged.
- Memory wait: mem_req=1, ack after 3 stalled cycles -> all enables 0 for 3 cycles, all 1 on the ack cycle, state RUN after, stall_count=3. Also mem_req=mem_ack=1 together -> no stall.
- Branch during wait: branch_taken=1 held through a 2-cycle wait -> no flush while waiting; if_id_flush=id_ex_flush=1 exactly on the ack cycle.
- Timeout: MEM_TIMEOUT=4, mem_req=1, ack never -> mem_error=1 after 4 stalled cycles, enables stay 0; a later ack is ignored; reset=0 for 1 edge -> mem_error=0, RUN, stall_count=0.
- Saturation/reset: CNT_W=4, 20-cycle memory stall with MEM_TIMEOUT=0 -> stall_count holds 15. Assert reset mid-stall -> next cycle state RUN, enables forced 0 during reset.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the MIPS pipeline datapath and the stall/flush controller.
// The pipeline (master) presents hazard sources; the controller (slave) returns stage enables and flushes.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             mem_req;
    logic             mem_ack;
    logic             branch_taken;

    logic             pc_enable;
    logic             if_id_enable;
    logic             if_id_flush;
    logic             id_ex_enable;
    logic             id_ex_flush;
    logic             ex_mem_enable;
    logic             mem_wb_enable;
    logic             mem_error;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_rs, id_rt, ex_mem_read, ex_rt, mem_req, mem_ack, branch_taken,
        input  pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush,
               ex_mem_enable, mem_wb_enable, mem_error, stall_count
    );

    modport slave (
        input  id_rs, id_rt, ex_mem_read, ex_rt, mem_req, mem_ack, branch_taken,
        output pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush,
               ex_mem_enable, mem_wb_enable, mem_error, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, multi-cycle data memory, taken-branch squash.
// Latency: controls are combinational from state and inputs; it is the stall source and takes no backpressure.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int               WAIT_W     = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_ERROR    = 2'd2;

    logic [1:0]        state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [CNT_W-1:0]  stall_cnt;

    logic pc_en, if_id_en, if_id_fl, id_ex_en, id_ex_fl, ex_mem_en, mem_wb_en;
    logic resolve;
    logic load_use;
    logic mem_stall;

    // r0 is hardwired zero, so a load targeting it never creates a dependency
    assign load_use  = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                       ((hz.ex_rt == hz.id_rs) || (hz.ex_rt == hz.id_rt));
    assign mem_stall = hz.mem_req && !hz.mem_ack;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        resolve      = 1'b0;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_fl     = 1'b0;
        id_ex_en     = 1'b0;
        id_ex_fl     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;

        case (state)
            S_RUN: begin
                if (mem_stall) begin
                    state_nxt    = (MEM_TIMEOUT == 1) ? S_ERROR : S_MEM_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end else begin
                    resolve = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                // A branch in EX stays frozen here and is resolved on the ack cycle
                if (!hz.mem_ack) begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                    if ((MEM_TIMEOUT != 0) && (wait_cnt_nxt == WAIT_LIMIT)) begin
                        state_nxt = S_ERROR;
                    end
                end else begin
                    resolve      = 1'b1;
                    state_nxt    = S_RUN;
                    wait_cnt_nxt = '0;
                end
            end
            S_ERROR: begin
                state_nxt = S_ERROR;
            end
            default: begin
                state_nxt    = S_RUN;
                wait_cnt_nxt = '0;
            end
        endcase

        if (resolve) begin
            if (hz.branch_taken) begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                if_id_fl  = 1'b1;
                id_ex_en  = 1'b1;
                id_ex_fl  = 1'b1;
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
            end else if (load_use) begin
                id_ex_en  = 1'b1;
                id_ex_fl  = 1'b1;
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
            end else begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
            end
        end

        if (!reset) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            if_id_fl  = 1'b0;
            id_ex_en  = 1'b0;
            id_ex_fl  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign hz.pc_enable     = pc_en;
    assign hz.if_id_enable  = if_id_en;
    assign hz.if_id_flush   = if_id_fl;
    assign hz.id_ex_enable  = id_ex_en;
    assign hz.id_ex_flush   = id_ex_fl;
    assign hz.ex_mem_enable = ex_mem_en;
    assign hz.mem_wb_enable = mem_wb_en;
    assign hz.mem_error     = (state == S_ERROR);
    assign hz.stall_count   = stall_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Three controller configurations driven by one random hazard stream and checked against a per-cycle model.
// Configs: default (64,16), short timeout (4,16), no timeout with a 4-bit counter (0,4).
module tb_pipeline_hazard_ctrl;
    localparam int NI = 3;
    localparam int TO [NI] = '{64, 4, 0};
    localparam int CW [NI] = '{16, 16, 4};

    logic clk = 1'b0;
    logic reset;
    logic [4:0] s_id_rs, s_id_rt, s_ex_rt;
    logic s_ex_mem_read, s_mem_req, s_mem_ack, s_branch;

    int checks = 0;
    int errors = 0;

    // Reference state: sticky error, consecutive stalled cycles, stall counter
    bit m_err [NI];
    int m_run [NI];
    int m_cnt [NI];
    logic [6:0] exp_c [NI];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) hz0 ();
    pipeline_hazard_ctrl_if #(.CNT_W(16)) hz1 ();
    pipeline_hazard_ctrl_if #(.CNT_W(4))  hz2 ();

    assign hz0.id_rs = s_id_rs; assign hz0.id_rt = s_id_rt; assign hz0.ex_rt = s_ex_rt;
    assign hz0.ex_mem_read = s_ex_mem_read; assign hz0.mem_req = s_mem_req;
    assign hz0.mem_ack = s_mem_ack; assign hz0.branch_taken = s_branch;
    assign hz1.id_rs = s_id_rs; assign hz1.id_rt = s_id_rt; assign hz1.ex_rt = s_ex_rt;
    assign hz1.ex_mem_read = s_ex_mem_read; assign hz1.mem_req = s_mem_req;
    assign hz1.mem_ack = s_mem_ack; assign hz1.branch_taken = s_branch;
    assign hz2.id_rs = s_id_rs; assign hz2.id_rt = s_id_rt; assign hz2.ex_rt = s_ex_rt;
    assign hz2.ex_mem_read = s_ex_mem_read; assign hz2.mem_req = s_mem_req;
    assign hz2.mem_ack = s_mem_ack; assign hz2.branch_taken = s_branch;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(64), .CNT_W(16)) dut0 (.clk(clk), .reset(reset), .hz(hz0));
    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4),  .CNT_W(16)) dut1 (.clk(clk), .reset(reset), .hz(hz1));
    pipeline_hazard_ctrl #(.MEM_TIMEOUT(0),  .CNT_W(4))  dut2 (.clk(clk), .reset(reset), .hz(hz2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Control vector order: pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en
    function automatic logic [6:0] obs_ctl(input int i);
        case (i)
            0: return {hz0.pc_enable, hz0.if_id_enable, hz0.if_id_flush, hz0.id_ex_enable,
                       hz0.id_ex_flush, hz0.ex_mem_enable, hz0.mem_wb_enable};
            1: return {hz1.pc_enable, hz1.if_id_enable, hz1.if_id_flush, hz1.id_ex_enable,
                       hz1.id_ex_flush, hz1.ex_mem_enable, hz1.mem_wb_enable};
            default: return {hz2.pc_enable, hz2.if_id_enable, hz2.if_id_flush, hz2.id_ex_enable,
                             hz2.id_ex_flush, hz2.ex_mem_enable, hz2.mem_wb_enable};
        endcase
    endfunction

    function automatic logic [31:0] obs_cnt(input int i);
        case (i)
            0: return 32'(hz0.stall_count);
            1: return 32'(hz1.stall_count);
            default: return 32'(hz2.stall_count);
        endcase
    endfunction

    function automatic logic obs_err(input int i);
        case (i)
            0: return hz0.mem_error;
            1: return hz1.mem_error;
            default: return hz2.mem_error;
        endcase
    endfunction

    function automatic bit stalled(input int i);
        // A fresh request without ack stalls; once waiting, only the ack releases
        return !s_mem_ack && (s_mem_req || (m_run[i] > 0));
    endfunction

    function automatic logic [6:0] model_ctl(input int i);
        bit dep;
        dep = s_ex_mem_read && (s_ex_rt != 0) && (s_ex_rt == s_id_rs || s_ex_rt == s_id_rt);
        if (!reset || m_err[i] || stalled(i)) return 7'b0000000;
        if (s_branch)                          return 7'b1111111;
        if (dep)                               return 7'b0001111;
        return 7'b1101011;
    endfunction

    task automatic model_clock(input int i);
        int cmax;
        cmax = (1 << CW[i]) - 1;
        if (!reset) begin
            m_err[i] = 0;
            m_run[i] = 0;
            m_cnt[i] = 0;
        end else begin
            if (exp_c[i][6] == 1'b0 && m_cnt[i] < cmax) m_cnt[i]++;
            if (!m_err[i]) begin
                if (stalled(i)) begin
                    m_run[i]++;
                    if (TO[i] != 0 && m_run[i] == TO[i]) m_err[i] = 1;
                end else begin
                    m_run[i] = 0;
                end
            end
        end
    endtask

    task automatic cycle(input logic rst, input logic req, input logic ack, input logic br,
                         input logic ld, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] ert);
        @(negedge clk);
        reset = rst; s_mem_req = req; s_mem_ack = ack; s_branch = br;
        s_ex_mem_read = ld; s_id_rs = rs; s_id_rt = rt; s_ex_rt = ert;
        #1;
        for (int i = 0; i < NI; i++) begin
            exp_c[i] = model_ctl(i);
            check($sformatf("cfg%0d ctl", i), 32'(obs_ctl(i)), 32'(exp_c[i]));
            check($sformatf("cfg%0d mem_error", i), 32'(obs_err(i)), 32'(m_err[i]));
            check($sformatf("cfg%0d stall_count", i), obs_cnt(i), 32'(m_cnt[i]));
        end
        @(posedge clk);
        for (int i = 0; i < NI; i++) model_clock(i);
    endtask

    initial begin
        int len, prof, ackp;
        logic rst, req, ack;
        reset = 1'b0; s_mem_req = 0; s_mem_ack = 0; s_branch = 0;
        s_ex_mem_read = 0; s_id_rs = 0; s_id_rt = 0; s_ex_rt = 0;
        for (int i = 0; i < NI; i++) begin
            m_err[i] = 0; m_run[i] = 0; m_cnt[i] = 0; exp_c[i] = '0;
        end
        repeat (2) @(posedge clk);

        // Directed opener: load-use, r0 load, branch over load-use, 3-cycle wait, 1-cycle access
        cycle(1, 0, 0, 0, 1, 5'd8, 5'd3, 5'd8);
        cycle(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
        cycle(1, 0, 0, 1, 1, 5'd8, 5'd3, 5'd8);
        repeat (3) cycle(1, 1, 0, 1, 0, 5'd1, 5'd2, 5'd3);
        cycle(1, 1, 1, 1, 0, 5'd1, 5'd2, 5'd3);
        cycle(1, 1, 1, 0, 0, 5'd1, 5'd2, 5'd3);

        for (int seg = 0; seg < 160; seg++) begin
            prof = $urandom_range(0, 3);
            len  = (prof == 2) ? $urandom_range(3, 80) : $urandom_range(1, 25);
            ackp = (prof == 0) ? 100 : (prof == 1) ? 35 : (prof == 2) ? 0 : 70;
            if ($urandom_range(0, 99) < 30) begin
                repeat ($urandom_range(1, 2)) cycle(0, $urandom_range(0, 1), 0, 0, 0, 0, 0, 0);
            end
            for (int c = 0; c < len; c++) begin
                rst = !(prof != 2 && $urandom_range(0, 99) < 1);
                req = (prof == 2) ? 1'b1 : 1'($urandom_range(0, 99) < 40);
                ack = 1'($urandom_range(0, 99) < ackp);
                cycle(rst, req, ack, 1'($urandom_range(0, 99) < 20), 1'($urandom_range(0, 99) < 50),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
